// File: rtl/ui_frame_pkg.sv
// ui_frame_pkg
// Shared definitions for the UART command-frame receiver and the command
// decoder that consumes its payload stream.
//   frame_state_t : receiver frame-sequencing states
//   SOF           : start-of-frame marker byte
//   ERR_*         : error codes, one per error pulse of the receiver
//   in_frame()    : true while a frame is being collected (OPC..CHK)
package ui_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_OPC   = 3'd1,
    ST_LEN   = 3'd2,
    ST_PAY   = 3'd3,
    ST_CHK   = 3'd4,
    ST_DRAIN = 3'd5
  } frame_state_t;

  localparam logic [7:0] SOF = 8'hA5;

  typedef logic [2:0] err_code_t;

  localparam err_code_t ERR_NONE = 3'd0;
  localparam err_code_t ERR_CHK  = 3'd1;  // checksum mismatch
  localparam err_code_t ERR_FRM  = 3'd2;  // stop-bit error on a byte
  localparam err_code_t ERR_TMO  = 3'd3;  // inter-byte timeout inside a frame
  localparam err_code_t ERR_LEN  = 3'd4;  // length byte above MAX_LEN
  localparam err_code_t ERR_OVR  = 3'd5;  // byte arrived while draining

  function automatic logic in_frame(input frame_state_t s);
    return s inside {ST_OPC, ST_LEN, ST_PAY, ST_CHK};
  endfunction

endpackage

// File: rtl/ui_frame_buf.sv
// ui_frame_buf
// Payload buffer: simple dual-port register array with a registered read.
//   clk, rst_n        : clock, synchronous active-low reset (read register only)
//   wr_en/addr/data   : write port
//   rd_en, rd_addr    : read request; rd_data updates on the next edge
//   rd_data           : registered read data, holds while rd_en=0
module ui_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  // NOTE: the array is deliberately left out of reset; every location is
  // written before it is read in a frame, and a reset would turn the array
  // into flops with a reset mux per bit.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // NOTE: sequential state is always assigned with <= so every register
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ui_uart_frame_rx.sv
// ui_uart_frame_rx
// Frame-level receiver behind ui_uart_rx. Parses SOF, opcode, length,
// payload and checksum, buffers the payload and releases it as a
// valid/ready stream only after the checksum verifies.
//   clk, rst_n            : clock, synchronous active-low reset
//   rx_data, rx_data_rdy  : received byte and its single-cycle strobe
//   frm_err               : stop-bit error qualifying rx_data
//   out_valid/ready/data  : payload beat handshake
//   out_last              : final beat of the frame
//   out_opcode, out_len   : frame header, stable while out_valid
//   err_chk/frm/tmo/len/ovr : single-cycle error pulses, one cycle after cause
module ui_uart_frame_rx
  import ui_frame_pkg::*;
#(
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_data_rdy,
  input  logic                         frm_err,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   out_data,
  output logic                         out_last,
  output logic [7:0]                   out_opcode,
  output logic [$clog2(MAX_LEN+1)-1:0] out_len,
  output logic                         err_chk,
  output logic                         err_frm,
  output logic                         err_tmo,
  output logic                         err_len,
  output logic                         err_ovr
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW    = $clog2(TIMEOUT_CYC);

  frame_state_t state, state_nxt;
  logic [7:0]       sum, sum_nxt;
  logic [7:0]       opcode, opcode_nxt;
  logic [LEN_W-1:0] len, len_nxt;
  logic [LEN_W-1:0] idx, idx_nxt;
  logic [LEN_W-1:0] rd_idx, rd_idx_nxt;
  logic [TW-1:0]    tmo_cnt, tmo_nxt;
  logic             out_valid_nxt, out_last_nxt;
  logic [7:0]       out_opcode_nxt;
  logic [LEN_W-1:0] out_len_nxt;
  err_code_t        err_nxt;

  logic             wr_en, rd_en;
  logic [AW-1:0]    wr_addr, rd_addr;
  logic [7:0]       wr_data;

  logic             byte_ok;
  logic [7:0]       chk_sum;

  assign byte_ok = rx_data_rdy && !frm_err;
  assign chk_sum = sum + rx_data;  // 8-bit: carries drop out

  // out_data is the buffer's read register, so it is loaded one edge ahead
  // of each beat and holds by itself under back-pressure.
  ui_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (out_data)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_nxt      = state;
    sum_nxt        = sum;
    opcode_nxt     = opcode;
    len_nxt        = len;
    idx_nxt        = idx;
    rd_idx_nxt     = rd_idx;
    tmo_nxt        = tmo_cnt;
    out_valid_nxt  = out_valid;
    out_last_nxt   = out_last;
    out_opcode_nxt = out_opcode;
    out_len_nxt    = out_len;
    err_nxt        = ERR_NONE;
    wr_en          = 1'b0;
    wr_addr        = idx[AW-1:0];
    wr_data        = rx_data;
    rd_en          = 1'b0;
    rd_addr        = '0;

    if (in_frame(state)) tmo_nxt = rx_data_rdy ? '0 : tmo_cnt + 1'b1;

    case (state)
      ST_IDLE: begin
        if (rx_data_rdy) begin
          if (frm_err) begin
            err_nxt = ERR_FRM;
          end else if (rx_data == SOF) begin
            state_nxt = ST_OPC;
            tmo_nxt   = '0;
          end
        end
      end

      ST_OPC: begin
        if (byte_ok) begin
          opcode_nxt = rx_data;
          sum_nxt    = rx_data;
          state_nxt  = ST_LEN;
        end
      end

      ST_LEN: begin
        if (byte_ok) begin
          if (rx_data > 8'(MAX_LEN)) begin
            err_nxt   = ERR_LEN;
            state_nxt = ST_IDLE;
          end else begin
            len_nxt = rx_data[LEN_W-1:0];
            sum_nxt = chk_sum;
            idx_nxt = '0;
            if (rx_data == 8'h00) begin
              // An empty frame still yields one zero beat: park a zero in
              // slot 0 so the drain path needs no special case.
              wr_en     = 1'b1;
              wr_addr   = '0;
              wr_data   = 8'h00;
              state_nxt = ST_CHK;
            end else begin
              state_nxt = ST_PAY;
            end
          end
        end
      end

      ST_PAY: begin
        if (byte_ok) begin
          wr_en   = 1'b1;
          sum_nxt = chk_sum;
          idx_nxt = idx + 1'b1;
          if (idx + 1'b1 == len) state_nxt = ST_CHK;
        end
      end

      ST_CHK: begin
        if (byte_ok) begin
          if (chk_sum == 8'h00) begin
            state_nxt      = ST_DRAIN;
            out_valid_nxt  = 1'b1;
            out_last_nxt   = (len <= LEN_W'(1));
            out_opcode_nxt = opcode;
            out_len_nxt    = len;
            rd_idx_nxt     = '0;
            rd_en          = 1'b1;
            rd_addr        = '0;
          end else begin
            err_nxt   = ERR_CHK;
            state_nxt = ST_IDLE;
          end
        end
      end

      ST_DRAIN: begin
        // Incoming bytes are dropped here; the buffer is still being read.
        if (rx_data_rdy) err_nxt = ERR_OVR;
        if (out_valid && out_ready) begin
          if (out_last) begin
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
            state_nxt     = ST_IDLE;
          end else begin
            rd_idx_nxt   = rd_idx + 1'b1;
            rd_en        = 1'b1;
            rd_addr      = AW'(rd_idx + 1'b1);
            out_last_nxt = (rd_idx + 1'b1 == len - 1'b1);
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    // Aborts common to every in-frame state. An arriving byte always
    // restarts the timeout, so a byte on the expiry cycle wins.
    if (in_frame(state)) begin
      if (rx_data_rdy && frm_err) begin
        state_nxt = ST_IDLE;
        err_nxt   = ERR_FRM;
      end else if (!rx_data_rdy && tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
        state_nxt = ST_IDLE;
        err_nxt   = ERR_TMO;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sum        <= '0;
      opcode     <= '0;
      len        <= '0;
      idx        <= '0;
      rd_idx     <= '0;
      tmo_cnt    <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_opcode <= '0;
      out_len    <= '0;
      err_chk    <= 1'b0;
      err_frm    <= 1'b0;
      err_tmo    <= 1'b0;
      err_len    <= 1'b0;
      err_ovr    <= 1'b0;
    end else begin
      state      <= state_nxt;
      sum        <= sum_nxt;
      opcode     <= opcode_nxt;
      len        <= len_nxt;
      idx        <= idx_nxt;
      rd_idx     <= rd_idx_nxt;
      tmo_cnt    <= tmo_nxt;
      out_valid  <= out_valid_nxt;
      out_last   <= out_last_nxt;
      out_opcode <= out_opcode_nxt;
      out_len    <= out_len_nxt;
      err_chk    <= (err_nxt == ERR_CHK);
      err_frm    <= (err_nxt == ERR_FRM);
      err_tmo    <= (err_nxt == ERR_TMO);
      err_len    <= (err_nxt == ERR_LEN);
      err_ovr    <= (err_nxt == ERR_OVR);
    end
  end

endmodule

// File: doc/ui_uart_frame_rx.md
# ui_uart_frame_rx

Frame-level controller that sits directly downstream of `ui_uart_rx`. It sequences the received byte stream into command frames of the form SOF, opcode, length, payload, checksum, and buffers up to `MAX_LEN` payload bytes. It releases a frame only after its checksum has been verified, as a valid/ready payload stream to the command decoder. It also detects and reports framing errors, inter-byte timeouts, oversize lengths, checksum failures and overruns.

## Interface
- `MAX_LEN`, 16: maximum payload bytes per frame (1..255).
- `TIMEOUT_CYC`, 2_000_000: clock cycles allowed between bytes inside a frame (≥2).
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset. One clock; reset is synchronous and active-low.
- `rx_data`  in  8  byte from `ui_uart_rx`; valid only when `rx_data_rdy`=1.
- `rx_data_rdy`  in  1  single-cycle byte strobe.
- `frm_err`  in  1  stop-bit error; sampled only when `rx_data_rdy`=1.
- `out_valid`  out  1  payload beat valid.
- `out_ready`  in  1  downstream accepts beat.
- `out_data`  out  8  payload byte.
- `out_last`  out  1  final beat of frame.
- `out_opcode`  out  8  frame opcode; stable while `out_valid`.
- `out_len`  out  $clog2(MAX_LEN+1)  frame length; stable while `out_valid`.
- `err_chk`, `err_frm`, `err_tmo`, `err_len`, `err_ovr`  out  1 each  single-cycle error pulses.

## Operation
- **States:** IDLE, OPC, LEN, PAY, CHK, DRAIN.
- **Byte acceptance:** a byte is accepted on any cycle with `rx_data_rdy`=1.
- **IDLE:** a byte equal to `SOF` (8'hA5) moves to OPC. Any other byte is ignored silently.
- **OPC:** latch opcode, clear the running sum, add the opcode to the sum, go to LEN.
- **LEN:**
  - If byte > `MAX_LEN`: pulse `err_len`, go to IDLE.
  - Otherwise latch it, add it to the sum, clear the write index.
  - Go to PAY if byte ≠ 0, else go to CHK.
- **PAY:** write the byte to `buf[idx]`, add it to the sum, increment `idx`. Go to CHK once `idx` reaches len.
- **CHK:**
  - If (sum + byte) mod 256 == 0, go to DRAIN.
  - Otherwise pulse `err_chk` and go to IDLE.
- **Checksum arithmetic:** 8-bit wraparound; carries are discarded.
- **DRAIN:**
  - Present `buf[rd_idx]`; `rd_idx` advances on `out_valid && out_ready`.
  - `out_last`=1 when `rd_idx` == len−1.
  - If len == 0: exactly one beat with `out_data`=0 and `out_last`=1.
  - After the last handshake, go to IDLE.
- **Framing error:** a byte arriving with `frm_err`=1 in any state other than DRAIN is discarded. In OPC..CHK it also aborts the frame to IDLE. `err_frm` pulses in all of these cases, including IDLE.
- **Timeout:**
  - In OPC..CHK a counter clears on every accepted byte and increments otherwise.
  - When it reaches `TIMEOUT_CYC`: pulse `err_tmo` and go to IDLE.
  - If a byte arrives in the same cycle the timeout would fire, the byte wins and the timeout does not fire.
- **DRAIN overrun:** any byte arriving in DRAIN is dropped, including SOF and including a byte on the last-handshake cycle. Pulse `err_ovr`; `err_frm` is not reported. Buffer and outputs are unaffected.
- **Error pulse cycle:** each error pulse is asserted in the cycle after the offending byte or timeout.

## Timing
- **Reset:** `rst_n`=0 at any time, including mid-frame or mid-DRAIN, forces the following on the next edge:
  - state IDLE;
  - `out_valid`, `out_last`, all `err_*` = 0;
  - `out_data`, `out_opcode`, `out_len` = 0;
  - counters and indices = 0.
  
  Buffer contents are not reset.
- **Latency:** checksum byte accepted in cycle N → `out_valid`=1 in cycle N+1.
- **Throughput:** one beat per cycle with `out_ready` held high.
- **Back-pressure:** `out_valid` never drops without a handshake. `out_data`, `out_last`, `out_opcode` and `out_len` stay stable while `out_valid && !out_ready`.
- **Return to IDLE:** IDLE is reached one cycle after the last handshake, and a SOF is accepted from that cycle.
- **Registered outputs:** all outputs come from registers; there is no combinational path from `rx_*` to any output.

## Structure
- **Package `ui_frame_pkg`:**
  - state enum `frame_state_t`;
  - `SOF` = 8'hA5;
  - error-code localparams shared with the decoder.
- **Sub-module `ui_frame_buf`:** simple dual-port register array, `MAX_LEN` × 8, with write port (`wr_en`, `wr_addr`, `wr_data`) and registered read (`rd_addr` → `rd_data`). The FSM, sum, counters and output regs stay in `ui_uart_frame_rx`.

## Test plan
1. **Good frame, no back-pressure.** Bytes A5 01 02 11 22 CA, `out_ready`=1 → two beats 11, 22; `out_last` on 22; `out_opcode`=01; `out_len`=2; no `err_*`.
2. **Bad checksum.** Bytes A5 01 02 11 22 CB → `err_chk` pulses once; `out_valid` never asserts; next good frame passes.
3. **Zero-length frame and leading noise.** Bytes 33 (noise) then A5 07 00 F9 → one beat `out_data`=00, `out_last`=1, `out_opcode`=07; the 33 is ignored.
4. **Timeout and boundary.**
   - Bytes A5 01 02 11, then silence `TIMEOUT_CYC` cycles → `err_tmo`, return to IDLE; following good frame accepted.
   - A byte arriving exactly on the timeout cycle is accepted instead.
5. **Back-pressure and overrun.** Good frame with `out_ready`=0 for 20 cycles, one byte injected during DRAIN → `err_ovr` pulse; `out_data`=11 stays stable; beats 11, 22 delivered once ready rises.
6. **Aborts and reset.**
   - `frm_err`=1 on the payload byte → `err_frm`, return to IDLE.
   - LEN byte 11h with `MAX_LEN`=16 → `err_len`.
   - `rst_n`=0 mid-PAY → all outputs 0 next cycle; next frame decodes correctly.
